// File: rtl/toy_bpu_btb_entry_buffer_if.sv
// toy_bpu_btb_entry_buffer_if: payload type plus the alloc, drain and bypass bundle of the BTB entry buffer.
package btb_entry_buffer_pkg;
    typedef struct packed {
        logic [7:0]  index;
        logic [11:0] tag;
        logic [31:0] entry;
        logic [1:0]  way_hit;
        logic        real_taken;
    } btb_entry_t;
endpackage

interface toy_bpu_btb_entry_buffer_if #(
    parameter int ENTRY_BUFFER_NUM       = 4,
    parameter int ENTRY_BUFFER_PTR_WIDTH = $clog2(ENTRY_BUFFER_NUM)
);
    import btb_entry_buffer_pkg::*;
    logic                                alloc_vld;
    btb_entry_t                          alloc_pld;
    logic                                btb_update_vld;
    logic                                btb_update_rdy;
    btb_entry_t                          btb_update_pld;
    btb_entry_t [ENTRY_BUFFER_NUM-1:0]   entry_buffer_pld;
    logic [ENTRY_BUFFER_PTR_WIDTH:0]     entry_buffer_ptr;
    logic [ENTRY_BUFFER_NUM-1:0]         entry_buffer_ena;
    logic                                drop_pulse;
    logic [ENTRY_BUFFER_PTR_WIDTH:0]     pending_cnt;
    modport master (
        output alloc_vld, alloc_pld, btb_update_vld,
        input  btb_update_rdy, btb_update_pld, entry_buffer_pld, entry_buffer_ptr,
               entry_buffer_ena, drop_pulse, pending_cnt
    );
    modport slave (
        input  alloc_vld, alloc_pld, btb_update_vld,
        output btb_update_rdy, btb_update_pld, entry_buffer_pld, entry_buffer_ptr,
               entry_buffer_ena, drop_pulse, pending_cnt
    );
endinterface

// File: rtl/toy_bpu_btb_entry_buffer.sv
// toy_bpu_btb_entry_buffer: circular pending-update buffer that coalesces, drops oldest on overflow
// and drains oldest first into BTB write slots.
module toy_bpu_btb_entry_buffer
    import btb_entry_buffer_pkg::*;
#(
    parameter int ENTRY_BUFFER_NUM       = 4,
    parameter int ENTRY_BUFFER_PTR_WIDTH = $clog2(ENTRY_BUFFER_NUM)
) (
    input logic                        clk,
    input logic                        rst_n,
    toy_bpu_btb_entry_buffer_if.slave  bus
);
    localparam int N  = ENTRY_BUFFER_NUM;
    localparam int PW = ENTRY_BUFFER_PTR_WIDTH;

    logic [PW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [N-1:0]           ena_q, ena_d, match, coal;
    btb_entry_t [N-1:0]     slot_q, slot_d;
    logic                   drop_q, drop_d;
    logic                   empty, full, drain;
    logic [PW-1:0]          wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[PW-1:0];
    assign rd_idx = rd_ptr_q[PW-1:0];
    assign empty  = wr_ptr_q == rd_ptr_q;
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign drain  = bus.btb_update_vld && !empty;

    // A slot leaving through the drain port this cycle cannot absorb a coalesce.
    always_comb begin
        match = '0;
        coal  = '0;
        for (int i = 0; i < N; i++) begin
            match[i] = ena_q[i] && slot_q[i].index == bus.alloc_pld.index && slot_q[i].tag == bus.alloc_pld.tag;
            coal[i]  = match[i] && !(drain && rd_idx == PW'(i));
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ena_d    = ena_q;
        slot_d   = slot_q;
        drop_d   = 1'b0;
        if (drain) begin
            ena_d[rd_idx] = 1'b0;
            rd_ptr_d      = rd_ptr_q + (PW+1)'(1);
        end
        if (bus.alloc_vld) begin
            if (|coal) begin
                for (int i = 0; i < N; i++)
                    if (coal[i]) slot_d[i] = bus.alloc_pld;
            end else begin
                slot_d[wr_idx] = bus.alloc_pld;
                ena_d[wr_idx]  = 1'b1;
                wr_ptr_d       = wr_ptr_q + (PW+1)'(1);
                if (full && !drain) begin
                    rd_ptr_d = rd_ptr_q + (PW+1)'(1);
                    drop_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ena_q    <= '0;
            slot_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ena_q    <= ena_d;
            slot_q   <= slot_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.btb_update_rdy   = drain;
    assign bus.btb_update_pld   = slot_q[rd_idx];
    assign bus.entry_buffer_pld = slot_q;
    assign bus.entry_buffer_ptr = wr_ptr_q;
    assign bus.entry_buffer_ena = ena_q;
    assign bus.drop_pulse       = drop_q;
    assign bus.pending_cnt      = wr_ptr_q - rd_ptr_q;
endmodule
